atri_trig_handoff: RTL and testbench

ATRI_TRIG_HANDOFF -- requirements
Module: atri_trig_handoff

---
 rtl/atri_trig_handoff_if.sv | 38 +++
 rtl/atri_trig_handoff.sv | 135 +++++++++++++
 tb/tb_atri_trig_handoff.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/atri_trig_handoff_if.sv
// rtl/atri_trig_handoff_if.sv - L4 trigger handoff bus between trigger logic and IRS readout
interface atri_trig_handoff_if #(
  parameter int NUM_L4    = 4,
  parameter int INFO_BITS = 32,
  parameter int NL4_BITS  = 2
);
  logic                          enable_i;
  logic                          irs_busy_i;
  logic [8:0]                    pretrig_i;
  logic [7:0]                    holdoff_i;
  logic [NUM_L4-1:0]             l4_req_i;
  logic [NUM_L4*INFO_BITS-1:0]   l4_info_i;
  logic                          trig_o;
  logic [8:0]                    trig_offset_o;
  logic [NUM_L4-1:0]             trig_l4_o;
  logic [NUM_L4-1:0]             trig_l4_new_o;
  logic [NL4_BITS-1:0]           trig_info_addr_i;
  logic                          trig_info_rd_i;
  logic [INFO_BITS-1:0]          trig_info_o;
  logic [15:0]                   trig_count_o;
  logic [15:0]                   drop_count_o;

  // Driver side: sources requests and reads back info words.
  modport master (
    output enable_i, irs_busy_i, pretrig_i, holdoff_i, l4_req_i, l4_info_i,
    output trig_info_addr_i, trig_info_rd_i,
    input  trig_o, trig_offset_o, trig_l4_o, trig_l4_new_o, trig_info_o,
    input  trig_count_o, drop_count_o
  );

  // Handoff block side.
  modport slave (
    input  enable_i, irs_busy_i, pretrig_i, holdoff_i, l4_req_i, l4_info_i,
    input  trig_info_addr_i, trig_info_rd_i,
    output trig_o, trig_offset_o, trig_l4_o, trig_l4_new_o, trig_info_o,
    output trig_count_o, drop_count_o
  );
endinterface

// File: rtl/atri_trig_handoff.sv
// rtl/atri_trig_handoff.sv - merges L4 trigger requests into single IRS triggers with holdoff window
module atri_trig_handoff #(
  parameter int NUM_L4    = 4,
  parameter int INFO_BITS = 32,
  parameter int NL4_BITS  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  atri_trig_handoff_if.slave   bus
);

  localparam logic [NL4_BITS:0] NUM_L4_W = NUM_L4[NL4_BITS:0];

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              hold_q, hold_d;
  logic [NUM_L4-1:0]       pending_q, pending_d;
  logic [INFO_BITS-1:0]    info_q [NUM_L4];
  logic                    trig_q, trig_d;
  logic [8:0]              offset_q, offset_d;
  logic [NUM_L4-1:0]       new_q;
  logic [INFO_BITS-1:0]    rdata_q, rdata_d;
  logic [15:0]             tcnt_q, tcnt_d;
  logic [15:0]             dcnt_q, dcnt_d;

  logic [NUM_L4-1:0]       accept;
  logic [NUM_L4-1:0]       clr_vec;
  logic                    any_drop;
  logic                    start;
  logic                    addr_ok;

  // Qualify requests against the pre-clear pending vector and decode the read-clear.
  always_comb begin
    accept  = '0;
    clr_vec = '0;
    addr_ok = ({1'b0, bus.trig_info_addr_i} < NUM_L4_W);
    for (int k = 0; k < NUM_L4; k++) begin
      accept[k]  = bus.enable_i & bus.l4_req_i[k] & ~pending_q[k] &
                   ((state_q == ST_MERGE) | ~bus.irs_busy_i);
      clr_vec[k] = bus.trig_info_rd_i & addr_ok &
                   (bus.trig_info_addr_i == NL4_BITS'(k));
    end
    // A request on a bit that cannot be taken counts once per cycle regardless of width.
    any_drop = bus.enable_i & (|(bus.l4_req_i & ~accept));
    start    = (state_q == ST_IDLE) & (|accept);
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // FSM next state: holdoff is captured on entry and counted down after the trigger cycle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_MERGE;
          hold_d  = bus.holdoff_i;
        end
      end
      ST_MERGE: begin
        if (hold_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next values.
  always_comb begin
    trig_d    = start;
    offset_d  = start ? bus.pretrig_i : offset_q;
    tcnt_d    = start ? tcnt_q + 16'd1 : tcnt_q;
    dcnt_d    = (any_drop && (dcnt_q != 16'hFFFF)) ? dcnt_q + 16'd1 : dcnt_q;
    pending_d = (pending_q & ~clr_vec) | accept;
    rdata_d   = rdata_q;
    if (bus.trig_info_rd_i) begin
      rdata_d = addr_ok ? info_q[bus.trig_info_addr_i] : '0;
    end
  end

  // Datapath registers, including per-L4 info capture on acceptance.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
      trig_q    <= 1'b0;
      offset_q  <= '0;
      new_q     <= '0;
      rdata_q   <= '0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
      for (int k = 0; k < NUM_L4; k++) begin
        info_q[k] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      trig_q    <= trig_d;
      offset_q  <= offset_d;
      new_q     <= accept;
      rdata_q   <= rdata_d;
      tcnt_q    <= tcnt_d;
      dcnt_q    <= dcnt_d;
      for (int k = 0; k < NUM_L4; k++) begin
        if (accept[k]) begin
          info_q[k] <= bus.l4_info_i[k*INFO_BITS +: INFO_BITS];
        end
      end
    end
  end

  assign bus.trig_o        = trig_q;
  assign bus.trig_offset_o = offset_q;
  assign bus.trig_l4_o     = pending_q;
  assign bus.trig_l4_new_o = new_q;
  assign bus.trig_info_o   = rdata_q;
  assign bus.trig_count_o  = tcnt_q;
  assign bus.drop_count_o  = dcnt_q;

endmodule

// File: tb/tb_atri_trig_handoff.sv
// tb/tb_atri_trig_handoff.sv - scoreboard bench for atri_trig_handoff
module tb_atri_trig_handoff;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  atri_trig_handoff_if #(.NUM_L4(4), .INFO_BITS(32), .NL4_BITS(2)) bus ();

  atri_trig_handoff #(.NUM_L4(4), .INFO_BITS(32), .NL4_BITS(2)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  logic         en_in = 1'b0;
  logic         busy_in = 1'b0;
  logic [8:0]   pre_in = '0;
  logic [7:0]   hold_in = '0;
  logic [3:0]   req_in = '0;
  logic [127:0] info_in = '0;
  logic [1:0]   addr_in = '0;
  logic         rd_in = 1'b0;

  assign bus.enable_i         = en_in;
  assign bus.irs_busy_i       = busy_in;
  assign bus.pretrig_i        = pre_in;
  assign bus.holdoff_i        = hold_in;
  assign bus.l4_req_i         = req_in;
  assign bus.l4_info_i        = info_in;
  assign bus.trig_info_addr_i = addr_in;
  assign bus.trig_info_rd_i   = rd_in;

  typedef struct {
    logic        trig;
    logic [8:0]  off;
    logic [3:0]  nw;
    logic [3:0]  l4;
    logic [15:0] tc;
    logic [15:0] dc;
  } ev_t;

  ev_t         evq[$];
  logic [31:0] rdq[$];

  // Reference model: pending set, stored info, counters, and the last cycle of the merge window.
  logic [3:0]  m_pend = '0;
  logic [31:0] m_info [4];
  logic [15:0] m_tc = '0;
  logic [15:0] m_drop = '0;
  logic [8:0]  m_off = '0;
  int          win_end = -1;
  int          n = 0;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_info = '0;
  bit          mon_en = 1'b0;
  logic        rd_d1;
  logic [31:0] saved0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] acc;
    logic       drp;
    logic       merge;
    merge = (n <= win_end);
    acc = '0;
    drp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (en_in && req_in[k]) begin
        if (!m_pend[k] && (merge || !busy_in)) acc[k] = 1'b1;
        else drp = 1'b1;
      end
    end
    if (rd_in) begin
      rdq.push_back(m_info[addr_in]);
      m_pend[addr_in] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      if (acc[k]) begin
        m_pend[k] = 1'b1;
        m_info[k] = info_in[k*32 +: 32];
      end
    end
    if (drp && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    if (acc != 0 && !merge) begin
      m_tc = m_tc + 16'd1;
      m_off = pre_in;
      win_end = n + 1 + int'(hold_in);
    end
    if (acc != 0) evq.push_back('{trig: !merge, off: m_off, nw: acc, l4: m_pend, tc: m_tc, dc: m_drop});
  endtask

  task automatic drive(input logic en, input logic busy, input logic [3:0] req, input logic [8:0] pre,
                       input logic [7:0] hold, input logic rd, input logic [1:0] addr);
    @(negedge clk);
    #1;
    en_in = en; busy_in = busy; req_in = req; pre_in = pre; hold_in = hold;
    rd_in = rd; addr_in = addr;
    info_in = {$urandom, $urandom, $urandom, $urandom};
    model_step();
    n++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'b0, 9'd0, 8'd0, 1'b0, 2'd0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    en_in = 0; busy_in = 0; req_in = 0; rd_in = 0; addr_in = 0;
    #1;
    check("rst_trig", bus.trig_o, 0);
    check("rst_l4", bus.trig_l4_o, 0);
    check("rst_new", bus.trig_l4_new_o, 0);
    check("rst_off", bus.trig_offset_o, 0);
    check("rst_info", bus.trig_info_o, 0);
    check("rst_tcnt", bus.trig_count_o, 0);
    check("rst_dcnt", bus.drop_count_o, 0);
    m_pend = '0; m_tc = '0; m_drop = '0; m_off = '0; win_end = -1;
    for (int k = 0; k < 4; k++) m_info[k] = '0;
    evq.delete();
    rdq.delete();
    last_info = '0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Delays the read strobe so the monitor knows when read data is due.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_d1 <= 1'b0;
    else rd_d1 <= bus.trig_info_rd_i;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a trigger/new-bit event or read data.
  initial begin
    ev_t ev;
    logic [31:0] exp_info;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (bus.trig_o || bus.trig_l4_new_o != 0) begin
          if (evq.size() == 0) begin
            check("unexpected_event", {bus.trig_o, bus.trig_l4_new_o}, 0);
          end else begin
            ev = evq.pop_front();
            check("ev_trig", bus.trig_o, ev.trig);
            check("ev_new", bus.trig_l4_new_o, ev.nw);
            check("ev_l4", bus.trig_l4_o, ev.l4);
            check("ev_off", bus.trig_offset_o, ev.off);
            check("ev_tcnt", bus.trig_count_o, ev.tc);
            check("ev_dcnt", bus.drop_count_o, ev.dc);
          end
        end
        if (rd_d1) begin
          if (rdq.size() == 0) begin
            check("read_queue_size", rdq.size(), 1);
          end else begin
            exp_info = rdq.pop_front();
            check("rd_info", bus.trig_info_o, exp_info);
            last_info = exp_info;
          end
        end else begin
          check("info_hold", bus.trig_info_o, last_info);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    for (int k = 0; k < 4; k++) m_info[k] = '0;
    do_reset();

    drive(1'b1, 1'b0, 4'b0101, 9'h1A5, 8'd4, 1'b0, 2'd0);
    saved0 = info_in[31:0];
    after_edge();
    check("d_trig", bus.trig_o, 1);
    check("d_new", bus.trig_l4_new_o, 4'b0101);
    check("d_l4", bus.trig_l4_o, 4'b0101);
    check("d_tcnt", bus.trig_count_o, 1);
    check("d_off", bus.trig_offset_o, 9'h1A5);
    idle();
    drive(1'b1, 1'b0, 4'b0010, 9'h033, 8'd7, 1'b0, 2'd0);
    after_edge();
    check("m_trig", bus.trig_o, 0);
    check("m_new", bus.trig_l4_new_o, 4'b0010);
    check("m_l4", bus.trig_l4_o, 4'b0111);
    drive(1'b1, 1'b0, 4'b0001, 9'h000, 8'd0, 1'b0, 2'd0);
    after_edge();
    check("rep_dcnt", bus.drop_count_o, 1);
    check("rep_l4", bus.trig_l4_o, 4'b0111);
    drive(1'b0, 1'b0, 4'b0000, 9'h000, 8'd0, 1'b1, 2'd0);
    after_edge();
    check("rd0_info", bus.trig_info_o, saved0);
    check("rd0_l4", bus.trig_l4_o, 4'b0110);
    repeat (3) idle();
    drive(1'b1, 1'b1, 4'b1000, 9'h000, 8'd0, 1'b0, 2'd0);
    after_edge();
    check("busy_trig", bus.trig_o, 0);
    check("busy_dcnt", bus.drop_count_o, 2);
    check("busy_l4", bus.trig_l4_o, 4'b0110);

    drive(1'b0, 1'b0, 4'b0, 9'd0, 8'd0, 1'b1, 2'd1);
    drive(1'b0, 1'b0, 4'b0, 9'd0, 8'd0, 1'b1, 2'd2);
    drive(1'b1, 1'b0, 4'b0011, 9'h0F0, 8'd8, 1'b0, 2'd0);
    after_edge();
    check("pre_rst_l4", bus.trig_l4_o, 4'b0011);
    idle();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      idle();
      after_edge();
      check("post_rst_trig", bus.trig_o, 0);
    end
    check("post_rst_tcnt", bus.trig_count_o, 0);

    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 4; k++) r[k] = ($urandom % 5 == 0);
      drive($urandom % 8 != 0, $urandom % 4 == 0, r, 9'($urandom), 8'($urandom_range(0, 6)),
            $urandom % 4 == 0, 2'($urandom));
    end
    repeat (10) idle();

    do_reset();
    drive(1'b1, 1'b0, 4'b0001, 9'h011, 8'd0, 1'b0, 2'd0);
    for (int i = 0; i < 65534; i++) begin
      drive(1'b1, 1'($urandom), 4'b0001, 9'd0, 8'd0, 1'b0, 2'd0);
    end
    after_edge();
    check("sat_fffe", bus.drop_count_o, 16'hFFFE);
    drive(1'b1, 1'b0, 4'b0001, 9'd0, 8'd0, 1'b0, 2'd0);
    after_edge();
    check("sat_ffff", bus.drop_count_o, 16'hFFFF);
    drive(1'b1, 1'b1, 4'b0001, 9'd0, 8'd0, 1'b0, 2'd0);
    after_edge();
    check("sat_hold", bus.drop_count_o, 16'hFFFF);
    repeat (4) idle();
    after_edge();
    check("evq_empty", evq.size(), 0);
    check("rdq_empty", rdq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
